// File: rtl/pass_timer_pkg.sv
// Shared types and constants for the pass countdown timer.
// BCD helpers keep the decrement rule in one place.
package pass_timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [7:0] BCD_ZERO     = 8'h10;
    localparam logic [7:0] BCD_MIN_LOAD = 8'h11;

    function automatic logic bcd_load_ok(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9)
            && (v >= BCD_MIN_LOAD);
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v[3:0] == 4'd0)
            return {v[7:4] - 4'd1, 4'd9};
        else
            return {v[7:4], v[3:0] - 4'd1};
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: counts enabled cycles, flags the last cycle of each period.
// Clear wins over enable so a restart always begins a fresh period.
module tick_gen #(
    parameter int unsigned CLK_DIV = 50_000_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        tick_o = en_i && (cnt_q == LAST);
        cnt_d  = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (tick_o)
            cnt_d = '0;
        else if (en_i)
            cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/pass_timer.sv
// BCD countdown timer with pause, restart and a one-cycle done pulse.
// Counts are held offset by +10 so the display value is o_Data - 10.
module pass_timer
    import pass_timer_pkg::*;
#(
    parameter int unsigned CLK_DIV = 50_000_000
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Start,
    input  logic [7:0] i_Load,
    input  logic       i_Pause,
    output logic [7:0] o_Data,
    output logic       o_Ctrl,
    output logic       o_Done
);

    state_t     state_q, state_d;
    logic [7:0] data_q, data_d;
    logic       ctrl_q, ctrl_d;
    logic       done_q, done_d;

    logic       start_ok;
    logic       tick_en;
    logic       tick;
    logic [7:0] dec_val;

    assign start_ok = i_Start && bcd_load_ok(i_Load);
    assign dec_val  = bcd_dec(data_q);

    // Prescaler only advances while the count is live; a pausing RUN cycle freezes it.
    assign tick_en = !start_ok
        && (((state_q == RUN) && !i_Pause) || (state_q == DONE));

    tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk_i (i_Clk),
        .rst_i (i_Rst),
        .en_i  (tick_en),
        .clr_i (start_ok),
        .tick_o(tick)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        done_d  = 1'b0;
        if (start_ok) begin
            state_d = RUN;
            data_d  = i_Load;
        end else begin
            unique case (state_q)
                IDLE: ;
                RUN: begin
                    if (i_Pause) begin
                        state_d = PAUSE;
                    end else if (tick) begin
                        data_d = dec_val;
                        if (dec_val == BCD_ZERO)
                            state_d = DONE;
                    end
                end
                PAUSE: begin
                    if (!i_Pause)
                        state_d = RUN;
                end
                DONE: begin
                    if (tick) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        ctrl_d = (state_d != IDLE);
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q <= IDLE;
            data_q  <= BCD_ZERO;
            ctrl_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
            done_q  <= done_d;
        end
    end

    assign o_Data = data_q;
    assign o_Ctrl = ctrl_q;
    assign o_Done = done_q;

endmodule

// File: tb/tb_pass_timer.sv
// Randomized and directed bench for pass_timer against a decimal model.
// The model tracks the displayed seconds as a plain integer.
module tb_pass_timer;

    localparam int DIV = 4;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic [7:0] load  = 8'h00;
    logic [7:0] data;
    logic       ctrl;
    logic       done;

    int n_checks = 0;
    int n_pass   = 0;

    // model: 0 idle, 1 run, 2 pause, 3 done; m_d = displayed seconds
    int m_mode = 0;
    int m_d    = 0;
    int m_ph   = 0;
    bit m_done = 1'b0;

    pass_timer #(
        .CLK_DIV(DIV)
    ) dut (
        .i_Clk  (clk),
        .i_Rst  (rst),
        .i_Start(start),
        .i_Load (load),
        .i_Pause(pause),
        .o_Data (data),
        .o_Ctrl (ctrl),
        .o_Done (done)
    );

    always #5 clk = ~clk;

    function automatic bit load_ok(input logic [7:0] v);
        int t = int'(v) / 16;
        int u = int'(v) % 16;
        return (t <= 9) && (u <= 9) && ((t * 10 + u) >= 11);
    endfunction

    function automatic logic [7:0] exp_data();
        int v = m_d + 10;
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    function automatic bit exp_ctrl();
        return m_mode != 0;
    endfunction

    task automatic m_reset();
        m_mode = 0;
        m_d    = 0;
        m_ph   = 0;
        m_done = 1'b0;
    endtask

    task automatic m_step();
        m_done = 1'b0;
        if (start && load_ok(load)) begin
            m_mode = 1;
            m_d    = (int'(load) / 16) * 10 + int'(load) % 16 - 10;
            m_ph   = 0;
        end else if (m_mode == 1) begin
            if (pause) begin
                m_mode = 2;
            end else begin
                m_ph++;
                if (m_ph == DIV) begin
                    m_ph = 0;
                    m_d--;
                    if (m_d == 0) m_mode = 3;
                end
            end
        end else if (m_mode == 2) begin
            if (!pause) m_mode = 1;
        end else if (m_mode == 3) begin
            m_ph++;
            if (m_ph == DIV) begin
                m_ph   = 0;
                m_mode = 0;
                m_done = 1'b1;
            end
        end
    endtask

    task automatic clk_step();
        m_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        start = 1'b0;
        pause = 1'b0;
        m_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (data !== 8'h10)
            $display("FAIL reset_data got %h want 10", data);
        else n_pass++;
        n_checks++;
        if (ctrl !== 1'b0)
            $display("FAIL reset_ctrl got %b want 0", ctrl);
        else n_pass++;
        n_checks++;
        if (done !== 1'b0)
            $display("FAIL reset_done got %b want 0", done);
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int done_at  = -1;
        int done_cnt = 0;
        load  = 8'h13;
        start = 1'b1;
        for (int i = 0; i <= 20; i++) begin
            clk_step();
            start = 1'b0;
            n_checks++;
            if ({data, ctrl, done} !== {exp_data(), exp_ctrl(), m_done})
                $display("FAIL basic cyc %0d got %h/%b/%b want %h/%b/%b",
                         i, data, ctrl, done, exp_data(), exp_ctrl(), m_done);
            else n_pass++;
            if (i == 12) begin
                n_checks++;
                if ({data, ctrl} !== {8'h10, 1'b1})
                    $display("FAIL basic_zero got %h/%b want 10/1", data, ctrl);
                else n_pass++;
            end
            if (done) begin
                done_at = i;
                done_cnt++;
            end
        end
        n_checks++;
        if (done_at != 16 || done_cnt != 1)
            $display("FAIL basic_done at %0d cnt %0d want 16/1", done_at, done_cnt);
        else n_pass++;
    endtask

    task automatic test_borrow();
        bit saw_bad = 1'b0;
        do_reset();
        load  = 8'h20;
        start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            clk_step();
            start = 1'b0;
            if (data == 8'h1F) saw_bad = 1'b1;
            n_checks++;
            if ({data, ctrl, done} !== {exp_data(), exp_ctrl(), m_done})
                $display("FAIL borrow cyc %0d got %h want %h", i, data, exp_data());
            else n_pass++;
            if (i == 4) begin
                n_checks++;
                if (data !== 8'h19)
                    $display("FAIL borrow_first got %h want 19", data);
                else n_pass++;
            end
        end
        n_checks++;
        if (saw_bad)
            $display("FAIL borrow_1f got 1f want never");
        else n_pass++;
    endtask

    task automatic test_invalid();
        logic [7:0] bad [2];
        bad[0] = 8'h1A;
        bad[1] = 8'h10;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            load  = bad[k];
            start = 1'b1;
            clk_step();
            start = 1'b0;
            clk_step();
            n_checks++;
            if ({data, ctrl, done} !== {8'h10, 1'b0, 1'b0})
                $display("FAIL invalid_%h got %h/%b/%b want 10/0/0",
                         bad[k], data, ctrl, done);
            else n_pass++;
        end
    endtask

    task automatic test_pause();
        bit found = 1'b0;
        int k = 0;
        do_reset();
        load  = 8'h17;
        start = 1'b1;
        for (int i = 0; i < 40 && !found; i++) begin
            clk_step();
            start = 1'b0;
            if (m_d == 5) found = 1'b1;
        end
        clk_step();
        pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            clk_step();
            n_checks++;
            if ({data, ctrl} !== {8'h15, 1'b1})
                $display("FAIL pause_hold cyc %0d got %h/%b want 15/1", i, data, ctrl);
            else n_pass++;
        end
        pause = 1'b0;
        while (k < 20 && data == 8'h15) begin
            clk_step();
            k++;
        end
        n_checks++;
        if (!found || k != 4 || data !== 8'h14)
            $display("FAIL pause_resume got %0d cyc/%h want 4/14", k, data);
        else n_pass++;
        for (int i = 0; i < 24; i++) begin
            clk_step();
            n_checks++;
            if ({data, ctrl, done} !== {exp_data(), exp_ctrl(), m_done})
                $display("FAIL pause_tail cyc %0d got %h/%b/%b want %h/%b/%b",
                         i, data, ctrl, done, exp_data(), exp_ctrl(), m_done);
            else n_pass++;
        end
    endtask

    task automatic test_start_on_tick();
        bit found = 1'b0;
        do_reset();
        load  = 8'h14;
        start = 1'b1;
        for (int i = 0; i < 40 && !found; i++) begin
            clk_step();
            start = 1'b0;
            if (m_mode == 1 && m_d == 2 && m_ph == DIV - 1) found = 1'b1;
        end
        load  = 8'h30;
        start = 1'b1;
        clk_step();
        start = 1'b0;
        n_checks++;
        if (!found || {data, ctrl, done} !== {8'h30, 1'b1, 1'b0})
            $display("FAIL start_tick got %h/%b/%b want 30/1/0", data, ctrl, done);
        else n_pass++;
    endtask

    task automatic test_done_restart();
        bit found = 1'b0;
        do_reset();
        load  = 8'h11;
        start = 1'b1;
        for (int i = 0; i < 40 && !found; i++) begin
            clk_step();
            start = 1'b0;
            if (m_mode == 3 && m_ph == DIV - 1) found = 1'b1;
        end
        load  = 8'h12;
        start = 1'b1;
        clk_step();
        start = 1'b0;
        n_checks++;
        if (!found || {data, ctrl, done} !== {8'h12, 1'b1, 1'b0})
            $display("FAIL done_restart got %h/%b/%b want 12/1/0", data, ctrl, done);
        else n_pass++;
        for (int i = 0; i < 14; i++) begin
            clk_step();
            n_checks++;
            if ({data, ctrl, done} !== {exp_data(), exp_ctrl(), m_done})
                $display("FAIL restart_tail cyc %0d got %h/%b/%b want %h/%b/%b",
                         i, data, ctrl, done, exp_data(), exp_ctrl(), m_done);
            else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        bit bad = 1'b0;
        do_reset();
        load  = 8'h13;
        start = 1'b1;
        clk_step();
        start = 1'b0;
        repeat (6) clk_step();
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({data, ctrl, done} !== {8'h10, 1'b0, 1'b0})
            $display("FAIL async_rst got %h/%b/%b want 10/0/0", data, ctrl, done);
        else n_pass++;
        m_reset();
        rst = 1'b0;
        for (int i = 0; i < 24; i++) begin
            clk_step();
            if (done !== 1'b0 || ctrl !== 1'b0 || data !== 8'h10) bad = 1'b1;
        end
        n_checks++;
        if (bad)
            $display("FAIL async_after got %h/%b/%b want 10/0/0", data, ctrl, done);
        else n_pass++;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            start = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 3) == 0)
                load = 8'($urandom_range(0, 255));
            else begin
                int v = $urandom_range(11, 29);
                load = 8'((v / 10) * 16 + (v % 10));
            end
            if ($urandom_range(0, 9) == 0) pause = ~pause;
            clk_step();
            n_checks++;
            if ({data, ctrl, done} !== {exp_data(), exp_ctrl(), m_done})
                $display("FAIL random cyc %0d got %h/%b/%b want %h/%b/%b",
                         i, data, ctrl, done, exp_data(), exp_ctrl(), m_done);
            else n_pass++;
        end
        start = 1'b0;
        pause = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow();
        test_invalid();
        test_pause();
        test_start_on_tick();
        test_done_restart();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
